// File: rtl/uart_resp_arb.sv
// uart_resp_arb: round-robin arbiter sharing one UART transmit path
// (trmt/resp/tx_done) among NUM_REQ byte-response requesters.
// The winner's byte is captured and a one-cycle trmt is issued. The arbiter
// then waits for a rising edge of tx_done and acknowledges the winner with done.
// Optional feature macro: UART_RESP_ARB_TIMEOUT_EN (WAIT abort after
// TIMEOUT_CYC cycles, reported on err). Default build: no timeout, err = 0.
module uart_resp_arb #(
  parameter int unsigned NUM_REQ = 4
`ifdef UART_RESP_ARB_TIMEOUT_EN
  , parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic                   tx_done,
  output logic                   trmt,
  output logic [7:0]             resp,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   busy
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]         state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      cur;
  logic               tx_done_ff;
  logic               rise;
  logic               timeout_hit;

  logic               win_vld;
  logic [PW-1:0]      win_idx;
  logic [PW:0]        scan_idx;
  logic [PW-1:0]      next_ptr;
  logic [7:0]         win_byte;

  assign rise = tx_done & ~tx_done_ff;

  // Round-robin scan starting at rr_ptr; first requesting index wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NUM_REQ))
        scan_idx = scan_idx - (PW+1)'(NUM_REQ);
      if (!win_vld && req[scan_idx[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[PW-1:0];
      end
    end
  end

  assign next_ptr = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
  assign win_byte = req_data[{win_idx, 3'b000} +: 8];

  // Track tx_done one cycle back so only a genuine rising edge completes WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_done_ff <= 1'b1;
    else        tx_done_ff <= tx_done;
  end

`ifdef UART_RESP_ARB_TIMEOUT_EN
  logic [19:0] wait_cnt;

  // Count WAIT cycles; held at zero outside WAIT so every WAIT entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             wait_cnt <= '0;
    else if (state == IDLE) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 20'd1;
  end

  // A rising tx_done in the same cycle takes precedence over the abort.
  assign timeout_hit = (state == WAIT) && !rise && (wait_cnt == TIMEOUT_CYC - 20'd1);

  // One-cycle error pulse for the requester whose transfer was aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err <= '0;
    else if (timeout_hit) err <= NUM_REQ'(1) << cur;
    else                  err <= '0;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = '0;
`endif

  // Arbitration/transfer FSM with registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cur    <= '0;
      trmt   <= 1'b0;
      resp   <= 8'h00;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      trmt <= 1'b0;
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            resp   <= win_byte;
            trmt   <= 1'b1;
            gnt    <= NUM_REQ'(1) << win_idx;
            cur    <= win_idx;
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (rise) begin
            done  <= NUM_REQ'(1) << cur;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timeout_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_resp_arb.md
Name: uart_resp_arb

Overview:
- Round-robin arbiter that shares the single UART transmit path (trmt/resp/tx_done of the UART wrapper) among NUM_REQ requesters that each need to send 8-bit response bytes.
- Captures the winning requester's byte, issues a one-cycle trmt, waits for transmit completion, then acknowledges that requester.
- Sits between the command-processing logic (motor, sensor and status responders) and the UART wrapper.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYC, 20'd1000000, clk cycles allowed in WAIT before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transmit request (level).
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- tx_done  in  1  from UART wrapper; high when the transmitter is idle or finished.
- trmt  out  1  one-cycle start pulse to UART wrapper.
- resp  out  8  byte presented to UART wrapper; held stable from the trmt cycle until the next grant.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; requester i's byte was captured.
- done  out  NUM_REQ  one-hot, one-cycle pulse; requester i's byte finished transmitting.
- err  out  NUM_REQ  one-hot, one-cycle pulse; requester i's transmit timed out (optional feature).
- busy  out  1  high in WAIT.

Behaviour:
- Reset (async, any state): state=IDLE; trmt, gnt, done, err, busy = 0; resp = 8'h00; rr_ptr = 0; tx_done_ff = 1.
- All outputs are registered. tx_done_ff is tx_done delayed one clk. rise = tx_done & ~tx_done_ff.
- States: IDLE, WAIT.
- IDLE:
  - If |req is high at clock edge E, select the winner: the first set bit of req scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - At E: resp <= req_data[winner]; trmt <= 1; gnt[winner] <= 1; cur <= winner; rr_ptr <= (winner+1) mod NUM_REQ; state <= WAIT.
  - If req == 0: hold.
- WAIT:
  - trmt and gnt return to 0 after one cycle; busy = 1.
  - On rise: done[cur] <= 1 for one cycle; state <= IDLE.
  - req is ignored in WAIT.
- Latency:
  - req high in IDLE at edge E -> gnt/trmt high for the cycle after E.
  - rise sampled at edge F -> done high for the cycle after F.
  - Minimum one IDLE cycle between done and the next gnt.
- Requester rules:
  - req_data must be valid in the cycle req is high. Data is captured at grant; the requester may change data or drop req after gnt.
  - Keeping req high after done is a new request.
  - Dropping req before grant cancels the request with no side effects.
- Simultaneous events:
  - Multiple reqs: exactly one gnt, in rotating order.
  - rise coinciding with a new req: done first; arbitration happens in the following IDLE cycle.
  - A stale-high tx_done at WAIT entry does not complete the transfer; only a rising edge does.
- rr_ptr wraps NUM_REQ-1 -> 0. It advances only on grant, never on done or timeout.

Optional Feature:
- Macro: UART_RESP_ARB_TIMEOUT_EN.
- Enabled:
  - A 20-bit wait counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 without rise: err[cur] <= 1 for one cycle, no done pulse, state <= IDLE.
  - rise and timeout in the same cycle: rise wins (done, no err).
- Disabled: no counter; err is tied to 0; WAIT lasts until rise.

Test Plan:
- Reset in WAIT with trmt just issued -> immediately trmt=0, busy=0, resp=8'h00, state IDLE; after release, req=4'b0100 with byte 8'hA5 -> gnt=4'b0100, resp=8'hA5.
- NUM_REQ=4, req=4'b0001, data0=8'h3C; model tx_done low 5 cycles then high -> trmt one cycle with resp=8'h3C, gnt=4'b0001, then done=4'b0001 one cycle after the tx_done edge.
- req=4'b1111 held, each done answered -> grant order 0,1,2,3,0 with resp=data of each; gnt never multi-hot.
- rr_ptr=2 (after granting 1), req=4'b0011 -> grant 0 (wrap-around), next grant 1.
- tx_done stuck high entering WAIT -> no done until tx_done falls and rises again; a req arriving mid-WAIT is granted only after done.
- With UART_RESP_ARB_TIMEOUT_EN, TIMEOUT_CYC=20, tx_done held low -> err[cur] pulses after 20 WAIT cycles, no done, next pending req granted; without the macro, err stays 0 and the arbiter remains in WAIT.
